// File: rtl/mmio_pkg.sv
// Shared memory-map constants and the captured-store record for the MMIO bridge.
// The window constants are also used by the address decoder and the dram mapping.
package mmio_pkg;

  localparam logic [31:0] MMIO_WIN_BASE = 32'h0000_0400;
  localparam int          MMIO_WIN_BITS = 10;
  localparam int          MMIO_DEPTH    = 4;

  typedef struct packed {
    logic [MMIO_WIN_BITS-3:0] off;
    logic [31:0]              data;
  } mmio_req_t;

  // True when adr lies in the 2**bits byte window that starts at base.
  function automatic logic in_window(input logic [31:0] adr,
                                     input logic [31:0] base,
                                     input int unsigned bits);
    logic [31:0] diff;
    diff = (adr ^ base) >> bits;
    return (diff == 32'd0);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with first-word-fall-through read port.
// A push while full is accepted when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mmio_store_bridge.sv
// Captures core stores that hit the peripheral window and drains them in order over valid/ready.
// Store visible on the output one edge after capture; full FIFO with no pop drops the store.
module mmio_store_bridge
  import mmio_pkg::*;
#(
  parameter logic [31:0] WIN_BASE = MMIO_WIN_BASE,
  parameter int          WIN_BITS = MMIO_WIN_BITS,
  parameter int          DEPTH    = MMIO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   MemWrite,
  input  logic [31:0]            DataAdr,
  input  logic [31:0]            WriteData,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIN_BITS-3:0]    out_off,
  output logic [31:0]            out_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   misalign,
  output logic [7:0]             drop_cnt,
  input  logic                   clr_flags
);

  // The packed record carries the package window width; keep WIN_BITS in step with it.
  mmio_req_t in_req, head_req;
  logic      hit, aligned, push, pop, drop, empty;
  logic      overflow_q, overflow_d;
  logic      misalign_q, misalign_d;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign hit     = MemWrite && in_window(DataAdr, WIN_BASE, WIN_BITS);
  assign aligned = (DataAdr[1:0] == 2'b00);
  assign pop     = out_valid && out_ready;
  assign push    = hit && aligned && (!full || pop);
  assign drop    = hit && aligned && full && !pop;

  assign in_req.off  = DataAdr[WIN_BITS-1:2];
  assign in_req.data = WriteData;

  sync_fifo #(
    .WIDTH ($bits(mmio_req_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .data_i  (in_req),
    .pop_i   (pop),
    .data_o  (head_req),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign out_valid = !empty;
  assign out_off   = head_req.off;
  assign out_data  = head_req.data;

  // A clear in the same cycle as a new error wins, so software never loses a clear.
  always_comb begin
    overflow_d = overflow_q;
    misalign_d = misalign_q;
    drop_cnt_d = drop_cnt_q;
    if (clr_flags) begin
      overflow_d = 1'b0;
      misalign_d = 1'b0;
      drop_cnt_d = 8'd0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) begin
          drop_cnt_d = drop_cnt_q + 8'd1;
        end
      end
      if (hit && !aligned) begin
        misalign_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
      misalign_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      overflow_q <= overflow_d;
      misalign_q <= misalign_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign overflow = overflow_q;
  assign misalign = misalign_q;
  assign drop_cnt = drop_cnt_q;

endmodule
